// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler: in-order request queue drained into timed closed-page ACT, RD/WR and PRE commands
module dram_cmd_scheduler #(
    parameter int QUEUE_DEPTH   = 16,
    parameter int T_RCD         = 24,
    parameter int T_CL          = 24,
    parameter int T_CWL         = 20,
    parameter int T_BURST       = 4,
    parameter int T_RP          = 24,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    input  logic [1:0]                   req_op,
    input  logic [ADDRESS_WIDTH-1:0]     req_address,
    output logic                         req_ready,
    output logic                         cmd_valid,
    output logic [2:0]                   cmd_type,
    output logic [1:0]                   cmd_bank_group,
    output logic [1:0]                   cmd_bank,
    output logic [13:0]                  cmd_addr,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         busy
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_NOP   = 2'd3;
    localparam logic [2:0] CMD_ACT = 3'd1, CMD_RD = 3'd2, CMD_WR = 3'd3, CMD_PRE = 3'd4;

    typedef logic [15:0] cnt_t;
    typedef struct packed {
        logic        wr;
        logic [13:0] row;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [10:0] col;
    } req_t;
    typedef enum logic [2:0] {IDLE, WAIT_RCD, ISSUE_RW, WAIT_DATA, PRECHARGE, WAIT_RP} state_t;

    req_t mem_q [QUEUE_DEPTH];
    req_t in_req, head, cur_q, cur_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic push, pop, start;
    state_t state_q, state_d;
    cnt_t cnt_q, cnt_d;
    logic cmd_valid_q, cmd_valid_d;
    logic [2:0] cmd_type_q, cmd_type_d;
    logic [1:0] cmd_bg_q, cmd_bg_d, cmd_bank_q, cmd_bank_d;
    logic [13:0] cmd_addr_q, cmd_addr_d;
    logic unused_addr;

    assign unused_addr = ^req_address[2:0];
    assign in_req = '{wr: req_op == OP_WRITE, row: req_address[31:18], bg: req_address[7:6],
                      bank: req_address[9:8], col: {req_address[17:10], req_address[5:3]}};
    assign head      = mem_q[rd_ptr_q];
    assign req_ready = count_q < CW'(QUEUE_DEPTH);
    assign push      = req_valid && req_ready && req_op != OP_NOP;
    // The final WAIT_RP cycle behaves as IDLE so back-to-back ACTs lose no cycle
    assign start     = state_q == IDLE || (state_q == WAIT_RP && cnt_q == '0);
    assign pop       = start && count_q != '0;
    assign count_d   = count_q + CW'(push) - CW'(pop);
    assign wr_ptr_d  = wr_ptr_q + PW'(push);
    assign rd_ptr_d  = rd_ptr_q + PW'(pop);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        cmd_valid_d = 1'b0;
        cmd_type_d  = '0;
        cmd_bg_d    = '0;
        cmd_bank_d  = '0;
        cmd_addr_d  = '0;
        if (start) begin
            state_d = pop ? (T_RCD > 1 ? WAIT_RCD : ISSUE_RW) : IDLE;
            if (pop) begin
                cur_d       = head;
                cnt_d       = cnt_t'(T_RCD > 1 ? T_RCD - 2 : 0);
                cmd_valid_d = 1'b1;
                cmd_type_d  = CMD_ACT;
                cmd_bg_d    = head.bg;
                cmd_bank_d  = head.bank;
                cmd_addr_d  = head.row;
            end
        end else begin
            unique case (state_q)
                WAIT_RCD: begin
                    state_d = cnt_q == '0 ? ISSUE_RW : WAIT_RCD;
                    cnt_d   = cnt_q - cnt_t'(1);
                end
                ISSUE_RW: begin
                    state_d     = WAIT_DATA;
                    cnt_d       = cnt_t'(cur_q.wr ? T_CWL + T_BURST - 2 : T_CL + T_BURST - 2);
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = cur_q.wr ? CMD_WR : CMD_RD;
                    cmd_bg_d    = cur_q.bg;
                    cmd_bank_d  = cur_q.bank;
                    cmd_addr_d  = {3'b000, cur_q.col};
                end
                WAIT_DATA: begin
                    state_d = cnt_q == '0 ? PRECHARGE : WAIT_DATA;
                    cnt_d   = cnt_q - cnt_t'(1);
                end
                PRECHARGE: begin
                    state_d     = WAIT_RP;
                    cnt_d       = cnt_t'(T_RP - 1);
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = CMD_PRE;
                    cmd_bg_d    = cur_q.bg;
                    cmd_bank_d  = cur_q.bank;
                end
                WAIT_RP: cnt_d = cnt_q - cnt_t'(1);
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= '0;
            cmd_bg_q    <= '0;
            cmd_bank_q  <= '0;
            cmd_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_bg_q    <= cmd_bg_d;
            cmd_bank_q  <= cmd_bank_d;
            cmd_addr_q  <= cmd_addr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) mem_q[wr_ptr_q] <= in_req;
    end

    assign cmd_valid      = cmd_valid_q;
    assign cmd_type       = cmd_type_q;
    assign cmd_bank_group = cmd_bg_q;
    assign cmd_bank       = cmd_bank_q;
    assign cmd_addr       = cmd_addr_q;
    assign queue_count    = count_q;
    assign busy           = state_q != IDLE;
endmodule
